// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, the Booth digit encoding, the iteration-count
// derivation and the window-to-digit recoding table.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Number of radix-4 digits over the (width+2)-bit extended multiplier.
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

  // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] window);
    booth_digit_e dig;
    case (window)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Booth partial-multiple selector: turns a 3-bit multiplier window into
// 0, +A, +2A, -A or -2A of the (WIDTH+2)-bit extended multiplicand.
// 2A always fits: the extended operand has two spare bits above the data.
module booth_digit_sel
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        [2:0]       window,
  input  logic        [WIDTH+1:0] a_ext,
  output logic signed [WIDTH+1:0] pp
);

  booth_digit_e     digit;
  logic [WIDTH+1:0] mag;

  // Recode the window, pick the magnitude, then negate by two's complement.
  always_comb begin
    digit = booth_decode(window);
    mag   = '0;
    case (digit)
      POS1, NEG1: mag = a_ext;
      POS2, NEG2: mag = a_ext << 1;
      default:    mag = '0;
    endcase
    if (digit == NEG1 || digit == NEG2) begin
      pp = ~mag + 1'b1;
    end else begin
      pp = mag;
    end
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier with start/busy/done handshake.
// One Booth digit is retired per BUSY cycle; P is loaded on entry to DONE.
// Optional build macro BOOTH_EARLY_TERM_EN: leave BUSY as soon as every
// remaining digit is zero, right-aligning the accumulator in that same step.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int ITER = booth_iter(WIDTH);
  localparam int EW   = WIDTH + 2;        // extended operand width
  localparam int AW   = 2 * EW;           // accumulator width
  localparam int CW   = $clog2(ITER + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [EW:0]          mb_q, mb_d;       // extended multiplier with mb[-1] at bit 0
  logic [EW-1:0]        a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic signed [EW-1:0] pp;
  logic [EW-1:0]        upper_sum;
  logic signed [AW-1:0] acc_iter;
  logic signed [AW-1:0] acc_final;
  logic [EW:0]          mb_shift;
  logic                 last_iter;
  logic                 finish;
  logic                 ext_a, ext_b;

  booth_digit_sel #(.WIDTH(WIDTH)) u_digit_sel (
    .window (mb_q[2:0]),
    .a_ext  (a_q),
    .pp     (pp)
  );

  // One iteration: add digit*A into the upper half, then shift both
  // accumulator and multiplier window right by one radix-4 digit.
  assign upper_sum = acc_q[AW-1:EW] + pp;
  assign acc_iter  = $signed({upper_sum, acc_q[EW-1:0]}) >>> 2;
  assign mb_shift  = $signed(mb_q) >>> 2;
  assign last_iter = (count_q == CW'(ITER - 1));
  assign ext_a     = is_signed & A[WIDTH-1];
  assign ext_b     = is_signed & B[WIDTH-1];

`ifdef BOOTH_EARLY_TERM_EN
  logic rest_uniform;
  // All remaining bits (reference bit included) equal -> every later digit is zero.
  assign rest_uniform = (mb_shift == '0) || (mb_shift == '1);
  assign finish       = last_iter || rest_uniform;
  assign acc_final    = acc_iter >>> (2 * (ITER - 1 - int'(count_q)));
`else
  assign finish       = last_iter;
  assign acc_final    = acc_iter;
`endif

  // Next-state, datapath and handshake outputs; everything holds by default.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mb_d    = mb_q;
    a_d     = a_q;
    p_d     = p_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          count_d = '0;
          acc_d   = '0;
          a_d     = {{2{ext_a}}, A};
          mb_d    = {{2{ext_b}}, B, 1'b0};
        end
      end
      BUSY: begin
        busy    = 1'b1;
        acc_d   = acc_iter;
        mb_d    = mb_shift;
        count_d = count_q + CW'(1);
        if (finish) begin
          state_d = DONE;
          acc_d   = acc_final;
          p_d     = acc_final[2*WIDTH-1:0];
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = BUSY;
          count_d = '0;
          acc_d   = '0;
          a_d     = {{2{ext_a}}, A};
          mb_d    = {{2{ext_b}}, B, 1'b0};
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset (reset aborts any op).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      mb_q    <= '0;
      a_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mb_q    <= mb_d;
      a_q     <= a_d;
      p_q     <= p_d;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences and a reference-model random sweep.
module tb_booth_mul_seq;

  localparam int W   = 32;
  localparam int LAT = W / 2 + 2;  // start cycle to done cycle, fixed-latency build

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .P         (P)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
    int             lat_et;  // expected latency with early termination, 0 = any
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then count cycles until done (bounded).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2*W-1:0] p, output int lat, output int nbusy,
                        output bit seen);
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; nbusy = 0; seen = 1'b0;
    while (lat < 60) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    p = P;
  endtask

  task automatic check_latency(input string name, input int lat, input int nbusy, input int lat_et);
`ifdef BOOTH_EARLY_TERM_EN
    if (lat_et != 0) check({name, "_lat_et"}, 64'(lat), 64'(lat_et));
    else             check({name, "_lat_range"}, 64'(lat >= 2 && lat <= LAT), 64'd1);
`else
    check({name, "_lat"}, 64'(lat), 64'(LAT));
    check({name, "_busy_cycles"}, 64'(nbusy), 64'(LAT - 1));
`endif
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  initial begin
    vec_t           vecs[$];
    logic [2*W-1:0] p;
    int             lat, nbusy;
    bit             seen;
    logic [W-1:0]   ra, rb;
    logic           rs;

    vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 3});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 2});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 2});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 64'h0000_0000_8000_0000, 2});
    vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000, 2});
    vecs.push_back('{32'h0000_0009, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_001B, 3});
    vecs.push_back('{32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_EDCC, 2});
    vecs.push_back('{32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 64'h0000_0004_FFFF_FFFB, 0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'h3FFF_FFFF_8000_0000, 0});
    vecs.push_back('{32'h1234_5678, 32'h0000_0003, 1'b1, 64'h0000_0000_369D_0368, 3});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000, 0});
    vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 0});

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_p", P, 64'd0);
    reset = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, p, lat, nbusy, seen);
      $display("vec %0d: a=%h b=%h s=%0d -> P=%h lat=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].s, p, lat);
      check($sformatf("vec%0d_done", i), 64'(seen), 64'd1);
      check($sformatf("vec%0d_p", i), p, vecs[i].p);
      check_latency($sformatf("vec%0d", i), lat, nbusy, vecs[i].lat_et);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_p_hold", i), P, vecs[i].p);
    end

    // start held high throughout: new operands during BUSY are ignored,
    // and start in the DONE cycle launches the second op back-to-back.
    @(negedge clk);
    A = 32'h0000_0007; B = 32'hFFFF_FFFD; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    A = 32'h0000_0010; B = 32'h0000_0020; is_signed = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("b2b op1: P=%h lat=%0d", P, lat);
    check("b2b1_done", 64'(done), 64'd1);
    check("b2b1_p", P, 64'hFFFF_FFFF_FFFF_FFEB);
`ifndef BOOTH_EARLY_TERM_EN
    check("b2b1_lat", 64'(lat), 64'(LAT));
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b2_busy", 64'(busy), 64'd1);
    check("b2b2_p_hold", P, 64'hFFFF_FFFF_FFFF_FFEB);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("b2b op2: P=%h lat=%0d", P, lat);
    check("b2b2_done", 64'(done), 64'd1);
    check("b2b2_p", P, 64'h0000_0000_0000_0200);
`ifndef BOOTH_EARLY_TERM_EN
    check("b2b2_lat", 64'(lat), 64'(LAT));
`endif
    @(posedge clk); #1;
    check("b2b_idle_busy", 64'(busy), 64'd0);
    check("b2b_idle_done", 64'(done), 64'd0);

    // Reset in the middle of an operation aborts it without a done pulse.
    @(negedge clk);
    A = 32'h0000_0007; B = 32'h1234_5678; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_p", P, 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    $display("abort: activity after reset=%0d", seen);
    check("abort_quiet", 64'(seen), 64'd0);
    run_op(32'h0000_0007, 32'h1234_5678, 1'b0, p, lat, nbusy, seen);
    $display("after abort: P=%h lat=%0d", p, lat);
    check("after_abort_done", 64'(seen), 64'd1);
    check("after_abort_p", p, 64'h0000_0000_7F6E_5D48);
    check_latency("after_abort", lat, nbusy, 0);
    @(posedge clk); #1;

    // Random sweep against the arithmetic reference, both modes; some
    // multipliers are narrowed so short operands exercise early finish.
    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 3 == 1) rb = rb >> $urandom_range(0, 31);
      if (n % 6 == 4) rb = ~(rb >> $urandom_range(0, 31));
      rs = n[0];
      run_op(ra, rb, rs, p, lat, nbusy, seen);
      $display("rnd %0d: a=%h b=%h s=%0d -> P=%h lat=%0d", n, ra, rb, rs, p, lat);
      check($sformatf("rnd%0d_done", n), 64'(seen), 64'd1);
      check($sformatf("rnd%0d_p", n), p, ref_mul(ra, rb, rs));
      check_latency($sformatf("rnd%0d", n), lat, nbusy, 0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
